// File: rtl/i2c_xlate_map_ctrl.sv
// I2C address translation map: 4-entry {valid, src, dst} table scanned one
// entry per clock, lowest matching index wins, with saturating hit/miss counters.
module i2c_xlate_map_ctrl #(
   parameter int ADDR_W = 7,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              cfg_wr_en,
   input  logic [1:0]        cfg_idx,
   input  logic [ADDR_W-1:0] cfg_src,
   input  logic [ADDR_W-1:0] cfg_dst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic              lk_req,
   input  logic [ADDR_W-1:0] lk_addr,
   output logic              lk_ack,
   output logic [ADDR_W-1:0] lk_addr_out,
   output logic              lk_hit,
   output logic              busy,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   state_t                       state;
   logic [1:0]                   idx;
   logic [ADDR_W-1:0]            addr_q;
   logic [3:0]                   ent_valid;
   logic [3:0][ADDR_W-1:0]       ent_src;
   logic [3:0][ADDR_W-1:0]       ent_dst;
   logic                         match;

   assign match = ent_valid[idx] && (ent_src[idx] == addr_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         idx         <= 2'd0;
         addr_q      <= '0;
         ent_valid   <= '0;
         ent_src     <= '0;
         ent_dst     <= '0;
         cfg_ready   <= 1'b1;
         busy        <= 1'b0;
         lk_ack      <= 1'b0;
         lk_hit      <= 1'b0;
         lk_addr_out <= '0;
         hit_count   <= '0;
         miss_count  <= '0;
      end else begin
         lk_ack <= 1'b0;
         case (state)
            IDLE: begin
               // Table write and lookup may share an edge; the scan starts on
               // the following edge and so sees the freshly written entry.
               if (cfg_wr_en && cfg_ready) begin
                  ent_valid[cfg_idx] <= cfg_valid;
                  ent_src[cfg_idx]   <= cfg_src;
                  ent_dst[cfg_idx]   <= cfg_dst;
               end
               if (lk_req) begin
                  busy      <= 1'b1;
                  cfg_ready <= 1'b0;
                  if (enable) begin
                     addr_q <= lk_addr;
                     idx    <= 2'd0;
                     state  <= SCAN;
                  end else begin
                     lk_addr_out <= lk_addr;
                     lk_hit      <= 1'b0;
                     lk_ack      <= 1'b1;
                     state       <= RESP;
                  end
               end
            end
            SCAN: begin
               // enable is deliberately ignored here so a started scan completes.
               if (match) begin
                  lk_addr_out <= ent_dst[idx];
                  lk_hit      <= 1'b1;
                  lk_ack      <= 1'b1;
                  state       <= RESP;
                  if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
               end else if (idx == 2'd3) begin
                  lk_addr_out <= addr_q;
                  lk_hit      <= 1'b0;
                  lk_ack      <= 1'b1;
                  state       <= RESP;
                  if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
               end else begin
                  idx <= idx + 2'd1;
               end
            end
            RESP: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cfg_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_xlate_map_ctrl.sv
// Directed bench for i2c_xlate_map_ctrl: hand-computed latencies, translated
// addresses, hit flags and counter values.
module tb_i2c_xlate_map_ctrl;
   localparam int ADDR_W = 7;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              cfg_wr_en;
   logic [1:0]        cfg_idx;
   logic [ADDR_W-1:0] cfg_src;
   logic [ADDR_W-1:0] cfg_dst;
   logic              cfg_valid;
   logic              cfg_ready;
   logic              lk_req;
   logic [ADDR_W-1:0] lk_addr;
   logic              lk_ack;
   logic [ADDR_W-1:0] lk_addr_out;
   logic              lk_hit;
   logic              busy;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_hits = 0;
   int exp_miss = 0;

   i2c_xlate_map_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_src(cfg_src),
      .cfg_dst(cfg_dst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .lk_req(lk_req), .lk_addr(lk_addr), .lk_ack(lk_ack),
      .lk_addr_out(lk_addr_out), .lk_hit(lk_hit), .busy(busy),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] i, input logic v,
                            input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d);
      @(negedge clk);
      cfg_wr_en = 1'b1; cfg_idx = i; cfg_valid = v; cfg_src = s; cfg_dst = d;
      @(posedge clk); #1;
      cfg_wr_en = 1'b0;
   endtask

   // Waits at most 20 edges for lk_ack after the sampling edge; returns to IDLE.
   task automatic lookup(input string tag, input logic [ADDR_W-1:0] a, input int exp_edges,
                         input logic [ADDR_W-1:0] exp_out, input logic exp_hit);
      int n;
      @(negedge clk);
      lk_req = 1'b1; lk_addr = a;
      @(posedge clk); #1;
      lk_req = 1'b0; cfg_wr_en = 1'b0;
      n = 0;
      while (!lk_ack && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, n, exp_edges);
      check({tag, " addr"}, lk_addr_out, exp_out);
      check({tag, " hit"}, lk_hit, exp_hit);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1; cfg_wr_en = 1'b0; cfg_idx = 2'd0;
      cfg_src = '0; cfg_dst = '0; cfg_valid = 1'b0; lk_req = 1'b0; lk_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst cfg_ready", cfg_ready, 1);
      check("rst busy", busy, 0);
      check("rst lk_ack", lk_ack, 0);
      check("rst lk_hit", lk_hit, 0);
      check("rst addr_out", lk_addr_out, 0);
      check("rst hit_count", hit_count, 0);
      check("rst miss_count", miss_count, 0);
      @(negedge clk); reset = 1'b1;

      // Hit at entry 2, then two misses
      cfg_write(2'd2, 1'b1, 7'h49, 7'h4A);
      lookup("hit49", 7'h49, 3, 7'h4A, 1'b1); exp_hits++;
      check("hit49 hit_count", hit_count, exp_hits);
      lookup("miss1A", 7'h1A, 4, 7'h1A, 1'b0); exp_miss++;
      check("miss1A miss_count", miss_count, exp_miss);
      lookup("miss48", 7'h48, 4, 7'h48, 1'b0); exp_miss++;
      check("miss48 miss_count", miss_count, exp_miss);

      // Pass-through
      enable = 1'b0;
      lookup("pass49", 7'h49, 0, 7'h49, 1'b0);
      check("pass hit_count", hit_count, exp_hits);
      check("pass miss_count", miss_count, exp_miss);
      check("pass ack low", lk_ack, 0);
      check("pass addr held", lk_addr_out, 7'h49);
      enable = 1'b1;

      // Duplicate entries: lowest index wins
      cfg_write(2'd0, 1'b1, 7'h48, 7'h10);
      cfg_write(2'd3, 1'b1, 7'h48, 7'h20);
      lookup("dup48", 7'h48, 1, 7'h10, 1'b1); exp_hits++;

      // Write during SCAN is ignored; enable drop mid-scan has no effect
      begin
         int n;
         @(negedge clk);
         lk_req = 1'b1; lk_addr = 7'h33;
         @(posedge clk); #1;
         lk_req = 1'b0;
         check("scan cfg_ready", cfg_ready, 0);
         check("scan busy", busy, 1);
         cfg_wr_en = 1'b1; cfg_idx = 2'd0; cfg_valid = 1'b1; cfg_src = 7'h48; cfg_dst = 7'h77;
         enable = 1'b0;
         @(posedge clk); #1;
         cfg_wr_en = 1'b0;
         n = 1;
         while (!lk_ack && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         exp_miss++;
         check("scan33 latency", n, 4);
         check("scan33 addr", lk_addr_out, 7'h33);
         check("scan33 hit", lk_hit, 0);
         check("scan33 miss_count", miss_count, exp_miss);
         @(posedge clk); #1;
         enable = 1'b1;
      end
      lookup("after ignored wr", 7'h48, 1, 7'h10, 1'b1); exp_hits++;

      // Same-edge write + lookup uses updated table
      @(negedge clk);
      cfg_wr_en = 1'b1; cfg_idx = 2'd1; cfg_valid = 1'b1; cfg_src = 7'h50; cfg_dst = 7'h51;
      lookup("same edge 50", 7'h50, 2, 7'h51, 1'b1); exp_hits++;
      check("same edge hit_count", hit_count, exp_hits);

      // Counter saturation
      for (int i = 0; i < 300; i++) lookup("sat50", 7'h50, 2, 7'h51, 1'b1);
      check("hit_count sat", hit_count, 255);
      check("miss_count steady", miss_count, exp_miss);

      // Reset mid-scan aborts without ack and clears the table
      begin
         int acks;
         @(negedge clk);
         lk_req = 1'b1; lk_addr = 7'h1A;
         @(posedge clk); #1;
         lk_req = 1'b0;
         @(negedge clk); reset = 1'b0;
         @(posedge clk); #1;
         check("abort busy", busy, 0);
         check("abort cfg_ready", cfg_ready, 1);
         check("abort lk_ack", lk_ack, 0);
         check("abort hit_count", hit_count, 0);
         check("abort addr_out", lk_addr_out, 0);
         @(negedge clk); reset = 1'b1;
         acks = 0;
         repeat (6) begin
            @(posedge clk); #1;
            if (lk_ack) acks++;
         end
         check("abort no ack", acks, 0);
      end
      lookup("post rst 49", 7'h49, 4, 7'h49, 1'b0);
      check("post rst miss_count", miss_count, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_xlate_map_ctrl.md
I2C_XLATE_MAP_CTRL -- requirements
Module: i2c_xlate_map_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 7, I2C address width.
REQ-002 SHALL have parameter: CNT_W, 8, hit/miss counter width.
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port: enable  input  1  1 = translate; 0 = pass-through.
REQ-006 SHALL have port: cfg_wr_en  input  1  table write strobe.
REQ-007 SHALL have port: cfg_idx  input  2  table entry index 0..3.
REQ-008 SHALL have port: cfg_src  input  ADDR_W  match address.
REQ-009 SHALL have port: cfg_dst  input  ADDR_W  replacement address.
REQ-010 SHALL have port: cfg_valid  input  1  entry valid bit.
REQ-011 SHALL have port: cfg_ready  output  1  table writable this cycle.
REQ-012 SHALL have port: lk_req  input  1  lookup request, level.
REQ-013 SHALL have port: lk_addr  input  ADDR_W  address to look up.
REQ-014 SHALL have port: lk_ack  output  1  one-cycle response strobe.
REQ-015 SHALL have port: lk_addr_out  output  ADDR_W  translated or original address.
REQ-016 SHALL have port: lk_hit  output  1  1 = table match.
REQ-017 SHALL have port: busy  output  1  lookup in progress.
REQ-018 SHALL have port: hit_count  output  CNT_W  saturating hit counter.
REQ-019 SHALL have port: miss_count  output  CNT_W  saturating miss counter.

Function
REQ-020 SHALL hold a 4-entry table {valid, src, dst}, written at a clock edge when cfg_wr_en=1 and cfg_ready=1; the write is ignored otherwise.
REQ-021 SHALL implement FSM states IDLE, SCAN, RESP; cfg_ready=1 only in IDLE; busy=1 in SCAN and RESP.
REQ-022 IDLE: lk_req=1 and enable=1 -> latch lk_addr, scan index=0, go SCAN; lk_req=1 and enable=0 -> result=lk_addr, hit=0, go RESP; else stay.
REQ-023 SCAN: entry[idx].valid and src==latched addr -> result=dst, hit=1, go RESP; else idx==3 -> result=latched addr, hit=0, go RESP; else idx+1, stay.
REQ-024 RESP: lk_ack=1 for exactly one cycle, lk_addr_out/lk_hit valid in that cycle, then go IDLE.
REQ-025 lk_addr_out and lk_hit SHALL hold their last response values until the next response.
REQ-026 Latency, counted from the edge sampling lk_req in IDLE: lk_ack high after k+1 edges for a hit at entry k, 4 edges for a miss, 0 edges (following cycle) when enable=0.
REQ-027 Duplicate matching entries: lowest index wins.
REQ-028 Simultaneous cfg write and lk_req in IDLE: both accepted on the same edge; the scan uses the updated table.
REQ-029 lk_req is sampled only in IDLE; a lk_req still high in the cycle after lk_ack starts a new lookup.
REQ-030 enable changes during SCAN SHALL NOT affect the lookup in progress.
REQ-031 hit_count +1 per hit response, miss_count +1 per miss response with enable=1; each saturates at 2^CNT_W-1; enable=0 responses change neither.

Reset
REQ-032 reset=0 at any clock edge SHALL force IDLE, clear all entry valid bits, src/dst=0, counters=0, lk_ack=0, lk_hit=0, lk_addr_out=0, busy=0, cfg_ready=1 after that edge; this overrides any in-flight lookup or write.
REQ-033 No lk_ack SHALL be produced for a lookup aborted by reset.

Verification
REQ-034 Program idx2 {1,0x49,0x4A}; lookup 0x49 -> lk_ack after 3 edges, lk_addr_out=0x4A, lk_hit=1, hit_count=1.
REQ-035 Lookup 0x1A on that table -> lk_ack after 4 edges, lk_addr_out=0x1A, lk_hit=0, miss_count=1; lookup 0x48 likewise misses.
REQ-036 enable=0, lookup 0x49 -> lk_ack in the next cycle, lk_addr_out=0x49, lk_hit=0, counters unchanged.
REQ-037 idx0 {1,0x48,0x10}, idx3 {1,0x48,0x20}; lookup 0x48 -> 0x10 after 1 edge; cfg write of idx0 during SCAN is ignored (cfg_ready=0), entry unchanged.
REQ-038 Write idx1 {1,0x50,0x51} on the same edge as lookup 0x50 -> hit, 0x51 after 2 edges; 300 hits -> hit_count=255.
REQ-039 reset=0 mid-SCAN -> next cycle IDLE, busy=0, no lk_ack; subsequent lookup 0x49 -> miss, 0x49.
